// File: rtl/modexp_ctrl_pkg.sv
// Shared types for the modular-exponentiation sequencer.
package modexp_ctrl_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_EXP_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TO_MONT_BASE,
    S_TO_MONT_ONE,
    S_SQUARE,
    S_MULTIPLY,
    S_FROM_MONT,
    S_FINISH
  } state_t;

  // States that hand an operand pair to the Montgomery multiplier.
  function automatic logic is_mm_state(state_t s);
    return (s == S_TO_MONT_BASE) || (s == S_TO_MONT_ONE) || (s == S_SQUARE) ||
           (s == S_MULTIPLY)     || (s == S_FROM_MONT);
  endfunction

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery
// multiplier; computes base^exp mod n.
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int EXP_WIDTH = DEFAULT_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     n,
  input  logic [WIDTH-1:0]     r2_mod_n,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_n,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done
);

  localparam int                IW      = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [WIDTH-1:0]  ONE     = WIDTH'(1);
  localparam logic [IW-1:0]     IDX_TOP = IW'(EXP_WIDTH - 1);

  state_t               state_q, state_d;
  logic                 issued_q;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]     base_q, n_q, r2_q, base_m_q, acc_q, result_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic                 op_state, capture;

  // A completion only counts once the operation has been issued.
  assign op_state = is_mm_state(state_q);
  assign capture  = op_state && issued_q && mm_done;

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FINISH);
  assign mm_start = op_state && !issued_q;
  assign mm_n     = n_q;
  assign result   = result_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    mm_a    = '0;
    mm_b    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TO_MONT_BASE;
          idx_d   = IDX_TOP;
        end
      end
      S_TO_MONT_BASE: begin
        mm_a = base_q;
        mm_b = r2_q;
        if (capture) state_d = S_TO_MONT_ONE;
      end
      S_TO_MONT_ONE: begin
        mm_a = ONE;
        mm_b = r2_q;
        if (capture) state_d = S_SQUARE;
      end
      S_SQUARE: begin
        mm_a = acc_q;
        mm_b = acc_q;
        if (capture) begin
          if (exp_q[idx_q])      state_d = S_MULTIPLY;
          else if (idx_q == '0)  state_d = S_FROM_MONT;
          else                   idx_d   = idx_q - 1'b1;
        end
      end
      S_MULTIPLY: begin
        mm_a = acc_q;
        mm_b = base_m_q;
        if (capture) begin
          if (idx_q == '0) begin
            state_d = S_FROM_MONT;
          end else begin
            state_d = S_SQUARE;
            idx_d   = idx_q - 1'b1;
          end
        end
      end
      S_FROM_MONT: begin
        mm_a = acc_q;
        mm_b = ONE;
        if (capture) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: the operand registers are reset along with the control state so the
  // multiplier sees all-zero operands and mm_n straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      issued_q <= 1'b0;
      idx_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      r2_q     <= '0;
      base_m_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      issued_q <= op_state && !capture;
      if (state_q == S_IDLE && start) begin
        base_q <= base;
        exp_q  <= exp;
        n_q    <= n;
        r2_q   <= r2_mod_n;
      end
      if (capture) begin
        unique case (state_q)
          S_TO_MONT_BASE:                    base_m_q <= mm_result;
          S_TO_MONT_ONE, S_SQUARE, S_MULTIPLY: acc_q  <= mm_result;
          S_FROM_MONT:                       result_q <= mm_result;
          default:                           ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl with a behavioural 7-cycle Montgomery
// multiplier and a plain-arithmetic modular-exponentiation reference.
module tb_modexp_ctrl;

  localparam int W  = 8;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  base, n, r2_mod_n;
  logic [EW-1:0] exp;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          mm_start, mm_done;
  logic [W-1:0]  mm_a, mm_b, mm_n, mm_result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .n(n),
    .r2_mod_n(r2_mod_n), .busy(busy), .done(done), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // a*b*R^-1 mod n, found by search rather than by REDC.
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] nn);
    int target;
    if (nn == 0) return '0;
    target = (int'(a) * int'(b)) % int'(nn);
    for (int x = 0; x < int'(nn); x++)
      if (((x << W) % int'(nn)) == target) return W'(x);
    return '0;
  endfunction

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [EW-1:0] e,
                                           input logic [W-1:0] nn);
    int r;
    r = 1 % int'(nn);
    for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(nn);
    return W'(r);
  endfunction

  function automatic int ref_ops(input logic [EW-1:0] e);
    return 3 + EW + $countones(e);
  endfunction

  // Multiplier model: mm_start in cycle c gives mm_done in cycle c+7.
  logic mm_busy;
  int   mm_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_done   <= 1'b0;
      mm_busy   <= 1'b0;
      mm_cnt    <= 0;
      mm_result <= '0;
    end else begin
      mm_done <= 1'b0;
      if (mm_start) begin
        mm_busy   <= 1'b1;
        mm_cnt    <= 6;
        mm_result <= mont(mm_a, mm_b, mm_n);
      end else if (mm_busy) begin
        if (mm_cnt == 1) begin
          mm_done <= 1'b1;
          mm_busy <= 1'b0;
        end else begin
          mm_cnt <= mm_cnt - 1;
        end
      end
    end
  end

  // Event counters and protocol watch; never cleared so runs take deltas.
  int   pulses = 0, dones = 0, proto_err = 0;
  logic prev_start = 1'b0;
  always @(posedge clk) begin
    prev_start <= mm_start;
    if (!rst && mm_start) begin
      pulses <= pulses + 1;
      if (mm_busy || prev_start) proto_err <= proto_err + 1;
    end
    if (!rst && done) dones <= dones + 1;
  end

  task automatic wait_done(input string name, output int cyc);
    bit seen = 0;
    cyc = 0;
    while (!seen && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1;
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
  endtask

  // One request end to end; harass re-pulses start with altered inputs while busy.
  task automatic run(input string name, input logic [W-1:0] b, input logic [EW-1:0] e,
                     input logic [W-1:0] nn, input logic [W-1:0] r2,
                     input logic [W-1:0] exp_res, input int exp_ops, input bit harass);
    int p0, d0, cyc;
    bit seen;
    base = b; exp = e; n = nn; r2_mod_n = r2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    p0 = pulses; d0 = dones;
    check({name, " busy after accept"}, 32'(busy), 32'd1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 3000) begin
      if (harass) begin
        start = (cyc % 3 == 0);
        base = ~b; exp = ~e; n = nn ^ 8'h10; r2_mod_n = ~r2;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1;
    end
    start = 1'b0; base = b; exp = e; n = nn; r2_mod_n = r2;
    check({name, " done seen"}, 32'(seen), 32'd1);
    // done becomes visible right after the edge 8*ops edges past the accept edge.
    check({name, " latency"}, 32'(cyc), 32'(8 * exp_ops));
    check({name, " result"}, 32'(result), 32'(exp_res));
    @(posedge clk); #1;
    check({name, " mm_start pulses"}, 32'(pulses - p0), 32'(exp_ops));
    check({name, " single done"}, 32'(dones - d0), 32'd1);
    check({name, " idle after done"}, {30'd0, busy, done}, 32'd0);
    check({name, " result held"}, 32'(result), 32'(exp_res));
  endtask

  typedef struct {
    string         name;
    logic [W-1:0]  b;
    logic [EW-1:0] e;
    logic [W-1:0]  nn;
    logic [W-1:0]  r2;
    logic [W-1:0]  res;
    int            ops;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [W-1:0] rn, rb, rr;
    logic [EW-1:0] re;

    // R = 256; for n = 13, R^2 mod n = 3.
    tbl[0] = '{"b2e5",     8'd2,  8'd5,   8'd13, 8'd3, 8'd6,  13};
    tbl[1] = '{"b12e255",  8'd12, 8'd255, 8'd13, 8'd3, 8'd12, 19};
    tbl[2] = '{"b7e0",     8'd7,  8'd0,   8'd13, 8'd3, 8'd1,  11};
    tbl[3] = '{"b0e3",     8'd0,  8'd3,   8'd13, 8'd3, 8'd0,  13};
    tbl[4] = '{"n1e0",     8'd0,  8'd0,   8'd1,  8'd0, 8'd0,  11};

    rst = 1'b1; start = 1'b0; base = '0; exp = '0; n = '0; r2_mod_n = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy/done/mm_start", {29'd0, busy, done, mm_start}, 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset mm operands", {8'd0, mm_a, mm_b, mm_n}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      run(tbl[i].name, tbl[i].b, tbl[i].e, tbl[i].nn, tbl[i].r2, tbl[i].res, tbl[i].ops, 1'b0);

    run("harass", 8'd2, 8'd5, 8'd13, 8'd3, 8'd6, 13, 1'b1);

    // Reset while squaring, then a clean request.
    base = 8'd2; exp = 8'd5; n = 8'd13; r2_mod_n = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid-reset busy/done/mm_start", {29'd0, busy, done, mm_start}, 32'd0);
    check("mid-reset result/mm_n", {16'd0, result, mm_n}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run("after reset", 8'd2, 8'd5, 8'd13, 8'd3, 8'd6, 13, 1'b0);

    // Back-to-back with start held high.
    base = 8'd2; exp = 8'd5; n = 8'd13; r2_mod_n = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    base = 8'd3; exp = 8'd4;
    wait_done("b2b first", cyc);
    check("b2b first result", 32'(result), 32'd6);
    @(posedge clk); #1;
    check("b2b idle gap busy", 32'(busy), 32'd0);
    check("b2b idle gap result", 32'(result), 32'd6);
    @(posedge clk); #1;
    check("b2b second accepted", 32'(busy), 32'd1);
    check("b2b result held", 32'(result), 32'd6);
    start = 1'b0;
    wait_done("b2b second", cyc);
    check("b2b second result", 32'(result), 32'd3);
    @(posedge clk); #1;

    // Random requests against the arithmetic reference.
    for (int k = 0; k < 25; k++) begin
      rn = W'($urandom_range(0, 127) * 2 + 1);
      rb = W'($urandom_range(0, int'(rn) - 1));
      re = EW'($urandom);
      rr = W'((1 << (2 * W)) % int'(rn));
      run($sformatf("rand%0d", k), rb, re, rn, rr, ref_pow(rb, re, rn), ref_ops(re), 1'b0);
    end

    check("multiplier protocol violations", 32'(proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
